// File: rtl/v2f_combinator_eval.sv
// v2f_combinator_eval: one Factorio-semantics combinator op per request.
// Define V2F_EVAL_POW_EN to build the iterative POW path; else op 5 is illegal.
module v2f_combinator_eval #(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic        out_err
);

`ifdef V2F_EVAL_POW_EN
  typedef enum logic [1:0] {IDLE, DIV, POW, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd3} state_t;
`endif

  localparam logic [5:0] LP_STEPS = 6'(DIV_STEPS);
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_MOD = 5'd4;
  localparam logic [4:0] OP_POW = 5'd5;

  state_t      r_state;
  logic        r_valid;
  logic [31:0] r_y;
  logic        r_err;
  logic        r_mod;
  logic        r_negq;
  logic        r_nega;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [5:0]  r_cnt;
`ifdef V2F_EVAL_POW_EN
  logic [31:0] r_acc;
  logic [31:0] r_base;
  logic [31:0] r_exp;
  logic [31:0] w_pow_acc;
`endif

  logic        w_accept;
  logic        w_idle;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_rem_in;
  logic [31:0] w_quo_in;
  logic [31:0] w_dvs_in;
  logic [31:0] w_shift;
  logic        w_ge;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic [31:0] w_alu;
  logic        w_ill;

  assign w_idle    = (r_state == IDLE);
  assign in_ready  = rst_n & w_idle;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_valid;
  assign out_y     = r_y;
  assign out_err   = r_err;

  assign w_abs_a = in_a[31] ? (~in_a + 32'd1) : in_a;
  assign w_abs_b = in_b[31] ? (~in_b + 32'd1) : in_b;

  // The first restoring step runs on the accept edge from the live operands.
  assign w_rem_in = w_idle ? 32'd0 : r_rem;
  assign w_quo_in = w_idle ? w_abs_a : r_quo;
  assign w_dvs_in = w_idle ? w_abs_b : r_dvs;
  assign w_shift  = {w_rem_in[30:0], w_quo_in[31]};
  assign w_ge     = (w_shift >= w_dvs_in);
  assign w_rem_nx = w_ge ? (w_shift - w_dvs_in) : w_shift;
  assign w_quo_nx = {w_quo_in[30:0], w_ge};
  assign w_q_fix  = r_negq ? (~r_quo + 32'd1) : r_quo;
  assign w_r_fix  = r_nega ? (~r_rem + 32'd1) : r_rem;

`ifdef V2F_EVAL_POW_EN
  assign w_pow_acc = r_exp[0] ? (r_acc * r_base) : r_acc;
`endif

  always_comb begin
    w_alu = '0;
    w_ill = 1'b0;
    case (in_op)
      5'd0:  w_alu = in_a + in_b;
      5'd1:  w_alu = in_a - in_b;
      5'd2:  w_alu = in_a * in_b;
      5'd3:  w_alu = '0;
      5'd4:  w_alu = '0;
`ifdef V2F_EVAL_POW_EN
      5'd5:  w_alu = '0;
`endif
      5'd6:  w_alu = in_a << in_b[4:0];
      5'd7:  w_alu = $signed(in_a) >>> in_b[4:0];
      5'd8:  w_alu = in_a & in_b;
      5'd9:  w_alu = in_a | in_b;
      5'd10: w_alu = in_a ^ in_b;
      5'd11: w_alu = {31'd0, in_a == in_b};
      5'd12: w_alu = {31'd0, in_a != in_b};
      5'd13: w_alu = {31'd0, $signed(in_a) <  $signed(in_b)};
      5'd14: w_alu = {31'd0, $signed(in_a) >  $signed(in_b)};
      5'd15: w_alu = {31'd0, $signed(in_a) <= $signed(in_b)};
      5'd16: w_alu = {31'd0, $signed(in_a) >= $signed(in_b)};
      5'd17: w_alu = ~in_a + 32'd1;
      5'd18: w_alu = ~in_a;
      default: w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_y     <= '0;
      r_err   <= 1'b0;
      r_mod   <= 1'b0;
      r_negq  <= 1'b0;
      r_nega  <= 1'b0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
`ifdef V2F_EVAL_POW_EN
      r_acc   <= '0;
      r_base  <= '0;
      r_exp   <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          if (in_op == OP_DIV || in_op == OP_MOD) begin
            r_state <= DIV;
            r_mod   <= (in_op == OP_MOD);
            r_negq  <= in_a[31] ^ in_b[31];
            r_nega  <= in_a[31];
            r_rem   <= w_rem_nx;
            r_quo   <= w_quo_nx;
            r_dvs   <= w_abs_b;
            r_cnt   <= 6'd1;
          end
`ifdef V2F_EVAL_POW_EN
          else if (in_op == OP_POW) begin
            if ($signed(in_b) <= 0) begin
              r_state <= DONE;
              r_valid <= 1'b1;
              r_y     <= (in_b == 32'd0) ? 32'd1 : 32'd0;
              r_err   <= 1'b0;
            end else begin
              r_state <= POW;
              r_acc   <= 32'd1;
              r_base  <= in_a;
              r_exp   <= in_b;
            end
          end
`endif
          else begin
            r_state <= DONE;
            r_valid <= 1'b1;
            r_y     <= w_alu;
            r_err   <= w_ill;
          end
        end
        DIV: begin
          if (r_cnt < LP_STEPS) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_state <= DONE;
            r_valid <= 1'b1;
            r_err   <= 1'b0;
            if (r_dvs == 32'd0) r_y <= '0;
            else r_y <= r_mod ? w_r_fix : w_q_fix;
          end
        end
`ifdef V2F_EVAL_POW_EN
        POW: begin
          r_acc  <= w_pow_acc;
          r_base <= r_base * r_base;
          r_exp  <= r_exp >> 1;
          if (r_exp[31:1] == 31'd0) begin
            r_state <= DONE;
            r_valid <= 1'b1;
            r_y     <= w_pow_acc;
            r_err   <= 1'b0;
          end
        end
`endif
        DONE: if (out_ready) begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v2f_combinator_eval.sv
// tb_v2f_combinator_eval: directed vectors for v2f_combinator_eval.
// Latency = negedges sampled after the accept edge until out_valid is seen.
module tb_v2f_combinator_eval;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        out_err;

  int n_vec;
  int n_err;

  v2f_combinator_eval dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, ".rdy"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 5'd0;
    in_a     = 32'hA5A5_A5A5;
    in_b     = 32'h5A5A_5A5A;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic run(input string tag, input logic [4:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ey, input logic ee, input int elat);
    int lat;
    issue(tag, op, a, b);
    wait_out(lat);
    check({tag, ".lat"}, lat, elat);
    check({tag, ".y"}, out_y, ey);
    check({tag, ".err"}, {31'd0, out_err}, {31'd0, ee});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    @(negedge clk);
    check("rst.rdy_low", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.y", out_y, 32'd0);
    check("rst.err", {31'd0, out_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.rdy_high", {31'd0, in_ready}, 32'd1);

    run("add_wrap", 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1);
    run("shl33", 5'd6, 32'd1, 32'd33, 32'd2, 1'b0, 1);
    run("sub", 5'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    run("mul_wrap", 5'd2, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1);
    run("mul_neg", 5'd2, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 1);
    run("shr_arith", 5'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
    run("and", 5'd8, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1);
    run("or", 5'd9, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0, 1);
    run("xor", 5'd10, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 1);
    run("eq", 5'd11, 32'd5, 32'd5, 32'd1, 1'b0, 1);
    run("ne", 5'd12, 32'd5, 32'd5, 32'd0, 1'b0, 1);
    run("gt", 5'd14, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1);
    run("le", 5'd15, 32'd3, 32'd3, 32'd1, 1'b0, 1);
    run("ge", 5'd16, 32'hFFFF_FFFB, 32'hFFFF_FFFC, 32'd0, 1'b0, 1);
    run("neg_min", 5'd17, 32'h8000_0000, 32'd9, 32'h8000_0000, 1'b0, 1);
    run("not", 5'd18, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b0, 1);

    run("div_m7_2", 5'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    run("mod_m7_2", 5'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    run("div_by0", 5'd3, 32'd5, 32'd0, 32'd0, 1'b0, 33);
    run("mod_7_m3", 5'd4, 32'd7, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    run("div_min_m1", 5'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
    run("div_100_7", 5'd3, 32'd100, 32'd7, 32'd14, 1'b0, 33);

`ifdef V2F_EVAL_POW_EN
    run("pow_3_4", 5'd5, 32'd3, 32'd4, 32'd81, 1'b0, 4);
    run("pow_2_31", 5'd5, 32'd2, 32'd31, 32'h8000_0000, 1'b0, 6);
    run("pow_5_m1", 5'd5, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    run("pow_0_0", 5'd5, 32'd0, 32'd0, 32'd1, 1'b0, 1);
    run("pow_m2_3", 5'd5, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFF8, 1'b0, 3);
`else
    run("op5_ill", 5'd5, 32'd3, 32'd4, 32'd0, 1'b1, 1);
`endif
    run("op25_ill", 5'd25, 32'd3, 32'd4, 32'd0, 1'b1, 1);

    issue("bp", 5'd13, 32'hFFFF_FFFF, 32'd0);
    wait_out(lat);
    check("bp.lat", lat, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp.hold_y", out_y, 32'd1);
      check("bp.hold_v", {31'd0, out_valid}, 32'd1);
      check("bp.hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp.rdy_after", {31'd0, in_ready}, 32'd1);
    check("bp.valid_after", {31'd0, out_valid}, 32'd0);

    issue("rst_div", 5'd3, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_div.rdy", {31'd0, in_ready}, 32'd1);
    check("rst_div.valid", {31'd0, out_valid}, 32'd0);
    check("rst_div.y", out_y, 32'd0);
    run("post_rst_add", 5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);
    run("post_rst_div", 5'd3, 32'd9, 32'd4, 32'd2, 1'b0, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
